// File: rtl/queue_fifo.sv
// queue_fifo: single-clock first-word-fall-through FIFO.
// The producer pushes at the tail and the consumer pops from the head. The head word is
// always visible on data_out, or zero when the queue is empty. A rejected push or pop
// raises a one-cycle registered overflow or underflow pulse.
module queue_fifo #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0] DepthCount = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] OneCount   = (ADDR_W + 1)'(1);

    // Storage is never reset; the pointers and count alone define what is valid.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic pop_ok;
    logic push_ok;

    // Status flags are decoded from the registered count, so they add no latency.
    always_comb begin
        full  = (count_q == DepthCount);
        empty = (count_q == '0);
    end

    // Accept/reject decisions. When the queue is full, a simultaneous pop frees the head
    // slot, so the push can still land at the tail.
    always_comb begin
        pop_ok      = enable & pop & ~empty;
        push_ok     = enable & push & (~full | pop_ok);
        overflow_d  = enable & push & full & ~pop_ok;
        underflow_d = enable & pop & empty;
    end

    // Next-state for the pointers and the occupancy count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + OneCount;
            2'b01:   count_d = count_q - OneCount;
            default: count_d = count_q;
        endcase
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Write the tail slot on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // Fall-through read of the head word; forced to zero when the queue is empty.
    always_comb begin
        data_out  = empty ? '0 : mem_q[rd_ptr_q];
        count     = count_q;
        overflow  = overflow_q;
        underflow = underflow_q;
    end

endmodule

// File: tb/tb_queue_fifo.sv
// tb_queue_fifo: directed checks of queue_fifo plus a short reference-queue run.
module tb_queue_fifo;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       push;
    logic       pop;
    logic [3:0] data_in;
    logic [3:0] data_out;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int n_checks;
    int n_errors;

    queue_fifo #(
        .DATA_W(4),
        .DEPTH (8),
        .ADDR_W(3)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .push     (push),
        .pop      (pop),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, then sample 1 ns after the edge with inputs idled.
    task automatic cycle(input logic en, input logic p, input logic q, input logic [3:0] d);
        enable  = en;
        push    = p;
        pop     = q;
        data_in = d;
        @(posedge clk);
        #1;
        enable  = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = 4'h0;
    endtask

    logic [3:0] model_q[$];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        enable   = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        data_in  = 4'h0;

        // Reset state
        #12;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: Asynchronous reset in the middle of traffic (count = 5)
        for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b1, 1'b0, 4'(i));
        check("mid_count5", 32'(count), 32'd5);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_empty", 32'(empty), 32'd1);
        check("async_full", 32'(full), 32'd0);
        check("async_dout", 32'(data_out), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 2: Fill, then overflow
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b1, 1'b0, 4'(i));
        check("fill_count", 32'(count), 32'd8);
        check("fill_full", 32'(full), 32'd1);
        check("fill_dout", 32'(data_out), 32'd1);
        cycle(1'b1, 1'b1, 1'b0, 4'hF);
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_dout", 32'(data_out), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 4'h0);
        check("ovf_clear", 32'(overflow), 32'd0);

        // 3: Drain in order, then underflow
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("drain_head%0d", i), 32'(data_out), 32'(i));
            cycle(1'b1, 1'b0, 1'b1, 4'h0);
        end
        check("drain_dout0", 32'(data_out), 32'd0);
        check("drain_empty", 32'(empty), 32'd1);
        cycle(1'b1, 1'b0, 1'b1, 4'h0);
        check("unf_pulse", 32'(underflow), 32'd1);
        check("unf_count", 32'(count), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 4'h0);
        check("unf_clear", 32'(underflow), 32'd0);

        // 4: Simultaneous push+pop, partially filled and full
        cycle(1'b1, 1'b1, 1'b0, 4'hA);
        cycle(1'b1, 1'b1, 1'b0, 4'hB);
        cycle(1'b1, 1'b1, 1'b0, 4'hC);
        check("abc_dout", 32'(data_out), 32'hA);
        cycle(1'b1, 1'b1, 1'b1, 4'hD);
        check("pp_dout", 32'(data_out), 32'hB);
        check("pp_count", 32'(count), 32'd3);
        for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b1, 1'b0, 4'(i));
        check("pp_full", 32'(full), 32'd1);
        cycle(1'b1, 1'b1, 1'b1, 4'h9);
        check("ppf_count", 32'(count), 32'd8);
        check("ppf_ovf", 32'(overflow), 32'd0);
        check("ppf_dout", 32'(data_out), 32'hC);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b1, 4'h0);
        check("ppf_last", 32'(data_out), 32'h9);
        check("ppf_cnt1", 32'(count), 32'd1);
        cycle(1'b1, 1'b0, 1'b1, 4'h0);
        check("ppf_empty", 32'(empty), 32'd1);

        // 5: Push+pop on an empty queue
        cycle(1'b1, 1'b1, 1'b1, 4'h6);
        check("epp_count", 32'(count), 32'd1);
        check("epp_dout", 32'(data_out), 32'h6);
        check("epp_unf", 32'(underflow), 32'd1);

        // 6: Enable low holds everything
        cycle(1'b1, 1'b1, 1'b0, 4'h3);
        cycle(1'b0, 1'b1, 1'b1, 4'hF);
        check("en0_count", 32'(count), 32'd2);
        check("en0_dout", 32'(data_out), 32'h6);
        check("en0_ovf", 32'(overflow), 32'd0);
        check("en0_unf", 32'(underflow), 32'd0);

        // 6: Random traffic across pointer wrap against a reference queue
        model_q.push_back(4'h6);
        model_q.push_back(4'h3);
        for (int i = 0; i < 20; i++) begin
            logic       p;
            logic       q;
            logic [3:0] d;
            logic       pop_ok;
            logic       push_ok;
            logic       exp_ovf;
            logic       exp_unf;
            p       = ($urandom_range(0, 9) < 6);
            q       = ($urandom_range(0, 9) < 5);
            d       = 4'($urandom_range(0, 15));
            pop_ok  = q && (model_q.size() > 0);
            push_ok = p && ((model_q.size() < 8) || pop_ok);
            exp_ovf = p && (model_q.size() == 8) && !pop_ok;
            exp_unf = q && (model_q.size() == 0);
            if (pop_ok) void'(model_q.pop_front());
            if (push_ok) model_q.push_back(d);
            cycle(1'b1, p, q, d);
            check($sformatf("rnd%0d_count", i), 32'(count), 32'(model_q.size()));
            check($sformatf("rnd%0d_dout", i), 32'(data_out),
                  (model_q.size() == 0) ? 32'd0 : 32'(model_q[0]));
            check($sformatf("rnd%0d_ovf", i), 32'(overflow), 32'(exp_ovf));
            check($sformatf("rnd%0d_unf", i), 32'(underflow), 32'(exp_unf));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
